// File: rtl/fsm_run_ctrl_pkg.sv
// Shared definitions for the fsm_run_ctrl sequencer: state encodings and state width.
// The encodings are fixed so that a testbench can observe the state register directly.
package fsm_run_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/hit_counter.sv
// Detection-pulse counter with synchronous clear.
// Wraps modulo 2^CNT_W by default; saturates at all-ones when FSM_RUN_CTRL_SAT_EN is defined.
module hit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
`ifdef FSM_RUN_CTRL_SAT_EN
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fsm_run_ctrl.sv
// Sequencer that loads a pattern, clears the detector, shifts the pattern out MSB-first and
// counts Mealy/Moore hits. Counters saturate instead of wrapping under FSM_RUN_CTRL_SAT_EN.
module fsm_run_ctrl
    import fsm_run_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              count_me,
    input  logic              count_mo,
    output logic              w,
    output logic              fsm_clr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  me_hits,
    output logic [CNT_W-1:0]  mo_hits
);

    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                w_q, w_d;
    logic                fsm_clr_q, fsm_clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                me_en_q, me_en_d;
    logic                mo_en_q, mo_en_d;

    // Outputs are registered from the current state, so the detector sees each phase one
    // cycle after the state is entered; the count enables are delayed the same way.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        w_d       = 1'b0;
        fsm_clr_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        me_en_d   = 1'b0;
        mo_en_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = data_in;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                fsm_clr_d = 1'b1;
                busy_d    = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy_d    = 1'b1;
                w_d       = shift_q[DATA_W-1];
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                me_en_d   = 1'b1;
                // Moore output reflects the previous bit, so the first shifted bit has no hit yet
                mo_en_d   = (bit_cnt_q != '0);
                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_d  = 1'b1;
                mo_en_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d    = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            w_q       <= 1'b0;
            fsm_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            me_en_q   <= 1'b0;
            mo_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            w_q       <= w_d;
            fsm_clr_q <= fsm_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            me_en_q   <= me_en_d;
            mo_en_q   <= mo_en_d;
        end
    end

    hit_counter #(.CNT_W(CNT_W)) u_me_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == ST_CLEAR),
        .inc   (me_en_q & count_me),
        .cnt   (me_hits)
    );

    hit_counter #(.CNT_W(CNT_W)) u_mo_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == ST_CLEAR),
        .inc   (mo_en_q & count_mo),
        .cnt   (mo_hits)
    );

    assign w       = w_q;
    assign fsm_clr = fsm_clr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
